// File: rtl/xadac_vec_lsu.sv
// Vector load/store issue stage feeding the xadac AXI width converter.
// Each request goes out as one full-width AXI beat; completions come back
// in request order through a small {we, tag} tracking FIFO.
module xadac_vec_lsu #(
  parameter int DataWidth = 64,
  parameter int AddrWidth = 32,
  parameter int IdWidth   = 4,
  parameter int AxiId     = 0,
  parameter int TagWidth  = 5,
  parameter int Depth     = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [AddrWidth-1:0]     req_addr,
  input  logic [DataWidth-1:0]     req_wdata,
  input  logic [DataWidth/8-1:0]   req_be,
  input  logic [TagWidth-1:0]      req_tag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_we,
  output logic [TagWidth-1:0]      rsp_tag,
  output logic [DataWidth-1:0]     rsp_rdata,
  output logic                     rsp_err,
  output logic [IdWidth-1:0]       aw_id,
  output logic [AddrWidth-1:0]     aw_addr,
  output logic [2:0]               aw_size,
  output logic                     aw_valid,
  input  logic                     aw_ready,
  output logic [DataWidth-1:0]     w_data,
  output logic [DataWidth/8-1:0]   w_strb,
  output logic                     w_last,
  output logic                     w_valid,
  input  logic                     w_ready,
  input  logic [IdWidth-1:0]       b_id,
  input  logic [1:0]               b_resp,
  input  logic                     b_valid,
  output logic                     b_ready,
  output logic [IdWidth-1:0]       ar_id,
  output logic [AddrWidth-1:0]     ar_addr,
  output logic [2:0]               ar_size,
  output logic                     ar_valid,
  input  logic                     ar_ready,
  input  logic [IdWidth-1:0]       r_id,
  input  logic [DataWidth-1:0]     r_data,
  input  logic [1:0]               r_resp,
  input  logic                     r_last,
  input  logic                     r_valid,
  output logic                     r_ready
);
  localparam int         StrbW   = DataWidth / 8;
  localparam int         PtrW    = $clog2(Depth);
  localparam logic [2:0] AxSize  = 3'($clog2(StrbW));
  localparam logic [PtrW:0] FullCnt = (PtrW+1)'(Depth);

  // issue slots
  logic                 aw_valid_q, aw_valid_d;
  logic [AddrWidth-1:0] aw_addr_q, aw_addr_d;
  logic                 w_valid_q, w_valid_d;
  logic [DataWidth-1:0] w_data_q, w_data_d;
  logic [StrbW-1:0]     w_strb_q, w_strb_d;
  logic                 ar_valid_q, ar_valid_d;
  logic [AddrWidth-1:0] ar_addr_q, ar_addr_d;

  // tracking FIFO
  logic [Depth-1:0]               fifo_we_q, fifo_we_d;
  logic [Depth-1:0][TagWidth-1:0] fifo_tag_q, fifo_tag_d;
  logic [PtrW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]                  cnt_q, cnt_d;

  // response register
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_we_q, rsp_we_d;
  logic [TagWidth-1:0]  rsp_tag_q, rsp_tag_d;
  logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;

  logic fifo_empty, fifo_full, head_we, rsp_free;
  logic req_fire, b_fire, r_fire, pop;

  // IDs, r_last and the low resp bit carry no information for this stage
  logic unused_inputs;
  assign unused_inputs = ^{b_id, r_id, r_last, b_resp[0], r_resp[0]};

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FullCnt);
  assign head_we    = fifo_we_q[rd_ptr_q];
  assign rsp_free   = !rsp_valid_q || rsp_ready;

  // one request in flight on the issue side at a time keeps the slots simple
  assign req_ready = !fifo_full && !aw_valid_q && !w_valid_q && !ar_valid_q;
  assign b_ready   = !fifo_empty && head_we && rsp_free;
  assign r_ready   = !fifo_empty && !head_we && rsp_free;
  assign req_fire  = req_valid && req_ready;
  assign b_fire    = b_valid && b_ready;
  assign r_fire    = r_valid && r_ready;
  assign pop       = b_fire || r_fire;

  assign aw_id     = IdWidth'(AxiId);
  assign ar_id     = IdWidth'(AxiId);
  assign aw_size   = AxSize;
  assign ar_size   = AxSize;
  assign w_last    = 1'b1;
  assign aw_addr   = aw_addr_q;
  assign aw_valid  = aw_valid_q;
  assign w_data    = w_data_q;
  assign w_strb    = w_strb_q;
  assign w_valid   = w_valid_q;
  assign ar_addr   = ar_addr_q;
  assign ar_valid  = ar_valid_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // issue slots: load on accept, each valid drops on its own handshake
  always_comb begin
    aw_valid_d = aw_valid_q;
    aw_addr_d  = aw_addr_q;
    w_valid_d  = w_valid_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    if (aw_valid_q && aw_ready) aw_valid_d = 1'b0;
    if (w_valid_q && w_ready)   w_valid_d  = 1'b0;
    if (ar_valid_q && ar_ready) ar_valid_d = 1'b0;
    if (req_fire) begin
      if (req_we) begin
        aw_valid_d = 1'b1;
        aw_addr_d  = req_addr;
        w_valid_d  = 1'b1;
        w_data_d   = req_wdata;
        w_strb_d   = req_be;
      end else begin
        ar_valid_d = 1'b1;
        ar_addr_d  = req_addr;
      end
    end
  end

  // tracking FIFO: push on accept, pop on B/R accept
  always_comb begin
    fifo_we_d  = fifo_we_q;
    fifo_tag_d = fifo_tag_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    if (req_fire) begin
      fifo_we_d[wr_ptr_q]  = req_we;
      fifo_tag_d[wr_ptr_q] = req_tag;
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({req_fire, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // response register: capture completion, hold until consumed
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_we_d    = rsp_we_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
    if (b_fire) begin
      rsp_valid_d = 1'b1;
      rsp_we_d    = 1'b1;
      rsp_tag_d   = fifo_tag_q[rd_ptr_q];
      rsp_rdata_d = '0;
      rsp_err_d   = b_resp[1];
    end else if (r_fire) begin
      rsp_valid_d = 1'b1;
      rsp_we_d    = 1'b0;
      rsp_tag_d   = fifo_tag_q[rd_ptr_q];
      rsp_rdata_d = r_data;
      rsp_err_d   = r_resp[1];
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_valid_q  <= 1'b0;
      aw_addr_q   <= '0;
      w_valid_q   <= 1'b0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      ar_valid_q  <= 1'b0;
      ar_addr_q   <= '0;
      fifo_we_q   <= '0;
      fifo_tag_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      aw_valid_q  <= aw_valid_d;
      aw_addr_q   <= aw_addr_d;
      w_valid_q   <= w_valid_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      ar_valid_q  <= ar_valid_d;
      ar_addr_q   <= ar_addr_d;
      fifo_we_q   <= fifo_we_d;
      fifo_tag_q  <= fifo_tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_we_q    <= rsp_we_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_xadac_vec_lsu.sv
// Bench for xadac_vec_lsu: queue-based model checked every cycle on the
// falling edge, plus directed scenarios with literal expectations.
module tb_xadac_vec_lsu;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic req_valid = 0, req_we = 0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_be = '0;
  logic [4:0]  req_tag = '0;
  logic req_ready;
  logic rsp_valid, rsp_ready = 1, rsp_we, rsp_err;
  logic [4:0]  rsp_tag;
  logic [63:0] rsp_rdata;
  logic [3:0]  aw_id, ar_id;
  logic [31:0] aw_addr, ar_addr;
  logic [2:0]  aw_size, ar_size;
  logic aw_valid, aw_ready = 1, w_last, w_valid, w_ready = 1;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic [3:0]  b_id = '0, r_id = '0;
  logic [1:0]  b_resp = '0, r_resp = '0;
  logic b_valid = 0, b_ready, ar_valid, ar_ready = 1;
  logic [63:0] r_data = '0;
  logic r_last = 1, r_valid = 0, r_ready;

  int total = 0;
  int bad = 0;

  xadac_vec_lsu #(.DataWidth(64), .AddrWidth(32), .IdWidth(4), .AxiId(0),
                  .TagWidth(5), .Depth(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_tag(rsp_tag), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_size(aw_size), .aw_valid(aw_valid),
    .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid),
    .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_size(ar_size), .ar_valid(ar_valid),
    .ar_ready(ar_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .r_valid(r_valid), .r_ready(r_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic we; logic [4:0] tag; } pend_t;
  pend_t pend_q[$];
  bit m_ar, m_aw, m_w;
  logic [31:0] m_ar_addr, m_aw_addr;
  logic [63:0] m_w_data;
  logic [7:0]  m_w_strb;
  bit m_rsp_v;
  logic m_rsp_we, m_rsp_err;
  logic [4:0]  m_rsp_tag;
  logic [63:0] m_rsp_rdata;
  int tag_log[$];

  // compare against the model, then advance it by what the next rising edge does
  always @(negedge clk) begin
    bit e_req, e_br, e_rr;
    pend_t h;
    if (!rstn) begin
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_ar_valid", ar_valid, 0);
      chk("rst_aw_valid", aw_valid, 0);
      chk("rst_w_valid", w_valid, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_r_ready", r_ready, 0);
      chk("rst_ar_addr", ar_addr, 0);
      chk("rst_aw_addr", aw_addr, 0);
      chk("rst_w_data", w_data, 0);
      chk("rst_w_strb", w_strb, 0);
      chk("rst_rsp_tag", rsp_tag, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      pend_q.delete();
      m_ar = 0; m_aw = 0; m_w = 0; m_rsp_v = 0;
    end else begin
      e_req = (pend_q.size() < DEPTH) && !m_ar && !m_aw && !m_w;
      e_br  = (pend_q.size() > 0) && pend_q[0].we && (!m_rsp_v || rsp_ready);
      e_rr  = (pend_q.size() > 0) && !pend_q[0].we && (!m_rsp_v || rsp_ready);
      chk("req_ready", req_ready, e_req);
      chk("b_ready", b_ready, e_br);
      chk("r_ready", r_ready, e_rr);
      chk("ar_valid", ar_valid, m_ar);
      chk("aw_valid", aw_valid, m_aw);
      chk("w_valid", w_valid, m_w);
      chk("axi_consts", {aw_id, ar_id, aw_size, ar_size, w_last}, {4'd0, 4'd0, 3'd3, 3'd3, 1'b1});
      if (m_ar) chk("ar_addr", ar_addr, m_ar_addr);
      if (m_aw) chk("aw_addr", aw_addr, m_aw_addr);
      if (m_w) begin
        chk("w_data", w_data, m_w_data);
        chk("w_strb", w_strb, m_w_strb);
      end
      chk("rsp_valid", rsp_valid, m_rsp_v);
      if (m_rsp_v) begin
        chk("rsp_we", rsp_we, m_rsp_we);
        chk("rsp_tag", rsp_tag, m_rsp_tag);
        chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
        chk("rsp_err", rsp_err, m_rsp_err);
      end
      if (r_valid) chk("r_last_high", r_last, 1);

      if (m_rsp_v && rsp_ready) begin
        tag_log.push_back(int'(m_rsp_tag));
        m_rsp_v = 0;
      end
      if (b_valid && e_br) begin
        h = pend_q.pop_front();
        m_rsp_v = 1; m_rsp_we = 1; m_rsp_tag = h.tag; m_rsp_rdata = '0; m_rsp_err = b_resp[1];
      end else if (r_valid && e_rr) begin
        h = pend_q.pop_front();
        m_rsp_v = 1; m_rsp_we = 0; m_rsp_tag = h.tag; m_rsp_rdata = r_data; m_rsp_err = r_resp[1];
      end
      if (m_ar && ar_ready) m_ar = 0;
      if (m_aw && aw_ready) m_aw = 0;
      if (m_w && w_ready)   m_w = 0;
      if (req_valid && e_req) begin
        pend_q.push_back({req_we, req_tag});
        if (req_we) begin
          m_aw = 1; m_aw_addr = req_addr;
          m_w = 1; m_w_data = req_wdata; m_w_strb = req_be;
        end else begin
          m_ar = 1; m_ar_addr = req_addr;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                          input logic [7:0] be, input logic [4:0] tag);
    bit ok = 0;
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be; req_tag = tag;
    for (int i = 0; i < 50; i++) begin
      if (req_ready) begin ok = 1; tick(); break; end
      tick();
    end
    req_valid = 0;
    chk("req_accept_in_time", ok, 1);
  endtask

  task automatic drive_r(input logic [63:0] d, input logic [1:0] resp);
    bit ok = 0;
    r_valid = 1; r_data = d; r_resp = resp; r_last = 1;
    for (int i = 0; i < 50; i++) begin
      if (r_ready) begin ok = 1; tick(); break; end
      tick();
    end
    r_valid = 0;
    chk("r_accept_in_time", ok, 1);
  endtask

  task automatic drive_b(input logic [1:0] resp);
    bit ok = 0;
    b_valid = 1; b_resp = resp;
    for (int i = 0; i < 50; i++) begin
      if (b_ready) begin ok = 1; tick(); break; end
      tick();
    end
    b_valid = 0;
    chk("b_accept_in_time", ok, 1);
  endtask

  task automatic chk_log(input string name, input int base, input int t0, input int n);
    chk({name, "_count"}, tag_log.size() - base, n);
    if (tag_log.size() >= base + n)
      for (int i = 0; i < n; i++) chk({name, "_order"}, tag_log[base+i], t0 + i);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int base;
    #2 rstn = 0;
    repeat (2) tick();
    rstn = 1;
    tick();

    // aligned load
    send_req(0, 32'h100, '0, '0, 5'd3);
    chk("t1_ar_valid", ar_valid, 1);
    chk("t1_ar_addr", ar_addr, 32'h100);
    chk("t1_ar_size", ar_size, 3);
    tick();
    drive_r(64'h1122334455667788, 2'b00);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp", {rsp_we, rsp_tag, rsp_err}, {1'b0, 5'd3, 1'b0});
    chk("t1_rsp_rdata", rsp_rdata, 64'h1122334455667788);
    tick();

    // unaligned store, W held off while AW completes
    w_ready = 0;
    send_req(1, 32'h103, 64'hA5A5_0000_FFFF_1234, 8'hFF, 5'd7);
    chk("t2_aw_addr", aw_addr, 32'h103);
    chk("t2_w_strb", w_strb, 8'hFF);
    chk("t2_w_last", w_last, 1);
    tick();
    chk("t2_aw_done_first", {aw_valid, w_valid}, 2'b01);
    repeat (2) tick();
    w_ready = 1;
    tick();
    chk("t2_w_done", w_valid, 0);
    drive_b(2'b10);
    chk("t2_rsp", {rsp_valid, rsp_we, rsp_tag, rsp_err}, {1'b1, 1'b1, 5'd7, 1'b1});
    chk("t2_rsp_rdata", rsp_rdata, 64'h0);
    tick();

    // ordering: R before B is stalled
    base = tag_log.size();
    send_req(1, 32'h200, 64'hDEAD_BEEF, 8'h0F, 5'd1);
    send_req(0, 32'h208, '0, '0, 5'd2);
    r_valid = 1; r_data = 64'h0202_0202_0202_0202; r_resp = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_r_stalled", r_ready, 0);
    end
    r_valid = 0;
    drive_b(2'b00);
    drive_r(64'h0202_0202_0202_0202, 2'b00);
    repeat (2) tick();
    chk_log("t3_log", base, 1, 2);

    // full FIFO, pop frees a slot, push+pop together holds the count
    base = tag_log.size();
    for (int i = 0; i < 4; i++) send_req(0, 32'h300 + 32'(i*8), '0, '0, 5'(10 + i));
    tick();
    req_valid = 1; req_we = 0; req_addr = 32'h340; req_tag = 5'd14;
    tick();
    chk("t4_full_blocks", req_ready, 0);
    r_valid = 1; r_data = 64'h10; r_resp = 0;
    tick();
    chk("t4_ready_after_pop", req_ready, 1);
    r_data = 64'h11;
    tick();
    req_valid = 0; r_valid = 0;
    tick();
    chk("t4_count_held", req_ready, 1);
    send_req(0, 32'h348, '0, '0, 5'd15);
    tick();
    chk("t4_full_again", req_ready, 0);
    for (int i = 0; i < 4; i++) drive_r(64'(32'h12 + i), 2'b00);
    repeat (2) tick();
    chk_log("t4_log", base, 10, 6);

    // response backpressure
    base = tag_log.size();
    rsp_ready = 0;
    send_req(0, 32'h400, '0, '0, 5'd20);
    send_req(0, 32'h408, '0, '0, 5'd21);
    tick();
    r_valid = 1; r_data = 64'hAAAA_0000_0000_0020; r_resp = 0;
    tick();
    r_data = 64'hBBBB_0000_0000_0021;
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold", {rsp_valid, rsp_tag}, {1'b1, 5'd20});
      chk("t5_hold_data", rsp_rdata, 64'hAAAA_0000_0000_0020);
      chk("t5_r_blocked", r_ready, 0);
      tick();
    end
    rsp_ready = 1;
    tick();
    r_valid = 0;
    chk("t5_second", {rsp_valid, rsp_tag}, {1'b1, 5'd21});
    chk("t5_second_data", rsp_rdata, 64'hBBBB_0000_0000_0021);
    tick();
    chk("t5_drained", rsp_valid, 0);
    tick();
    chk_log("t5_log", base, 20, 2);

    // reset with AR pending and two outstanding
    send_req(0, 32'h500, '0, '0, 5'd25);
    tick();
    ar_ready = 0;
    send_req(0, 32'h508, '0, '0, 5'd26);
    tick();
    chk("t6_pre_ar_valid", ar_valid, 1);
    rstn = 0;
    #1;
    chk("t6_ar_cleared", ar_valid, 0);
    chk("t6_req_ready", req_ready, 1);
    chk("t6_rsp_valid", rsp_valid, 0);
    tick();
    rstn = 1; ar_ready = 1;
    tick();
    chk("t6_post_req_ready", req_ready, 1);
    chk("t6_post_r_ready", r_ready, 0);
    send_req(0, 32'h600, '0, '0, 5'd30);
    tick();
    drive_r(64'h3030_3030, 2'b00);
    chk("t6_rsp", {rsp_valid, rsp_tag}, {1'b1, 5'd30});
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
